// File: rtl/pipe_if_stage.sv
// Instruction fetch + IF/ID register: PC select, wait-state imem, delay-slot-safe redirect (IF_PERF_EN adds counters).
// Latency: one edge from a ready fetch to inst/dpc4; imem_addr is the PC register itself.
// Backpressure: wpcir=0 freezes everything; imem_ready=0 injects NOP bubbles and parks taken redirects in REDIR.
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] da,
    input  logic        wpcir,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        redir_pend
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble
`endif
);

    typedef enum logic {RUN, REDIR} state_t;

    state_t      state, state_nx;
    logic [31:0] pend_pc, pend_nx;
    logic [31:0] pc_nx, dpc4_nx, inst_nx;
    logic [31:0] pc4, target;
    logic        fetch_ev, bubble_ev;

    assign pc4        = pc + 32'd4;
    assign imem_addr  = pc;
    assign redir_pend = (state == REDIR);

    always_comb begin
        unique case (pcsource)
            2'b00:   target = pc4;
            2'b01:   target = bpc;
            2'b10:   target = da;
            default: target = jpc;
        endcase
    end

    always_comb begin
        state_nx  = state;
        pend_nx   = pend_pc;
        pc_nx     = pc;
        dpc4_nx   = dpc4;
        inst_nx   = inst;
        fetch_ev  = 1'b0;
        bubble_ev = 1'b0;
        if (wpcir) begin
            dpc4_nx = pc4;
            if (imem_ready) begin
                fetch_ev = 1'b1;
                inst_nx  = imem_rdata;
                if (state == REDIR) begin
                    pc_nx    = pend_pc;
                    state_nx = RUN;
                end else begin
                    pc_nx = target;
                end
            end else begin
                // The branch leaves ID on this edge; remember its target until the delay slot lands.
                bubble_ev = 1'b1;
                inst_nx   = NOP;
                if (state == RUN && pcsource != 2'b00) begin
                    pend_nx  = target;
                    state_nx = REDIR;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= RUN;
            pend_pc <= 32'd0;
            pc      <= RESET_PC;
            dpc4    <= 32'd0;
            inst    <= NOP;
        end else begin
            state   <= state_nx;
            pend_pc <= pend_nx;
            pc      <= pc_nx;
            dpc4    <= dpc4_nx;
            inst    <= inst_nx;
        end
    end

`ifdef IF_PERF_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perf_fetch  <= 32'd0;
            perf_bubble <= 32'd0;
        end else begin
            if (fetch_ev)  perf_fetch  <= perf_fetch + 32'd1;
            if (bubble_ev) perf_bubble <= perf_bubble + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed bench for pipe_if_stage; imem returns {16'hC0DE, addr[15:0]} for every address.
module tb_pipe_if_stage;

    logic        clock = 1'b0;
    logic        resetn;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, da;
    logic        wpcir;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_ready;
    logic [31:0] pc, dpc4, inst;
    logic        redir_pend;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch, perf_bubble;
`endif

    int vectors = 0;
    int miscompares = 0;

    pipe_if_stage dut (
        .clock      (clock),
        .resetn     (resetn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .da         (da),
        .wpcir      (wpcir),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc         (pc),
        .dpc4       (dpc4),
        .inst       (inst),
        .redir_pend (redir_pend)
`ifdef IF_PERF_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_bubble(perf_bubble)
`endif
    );

    always #5 clock = ~clock;

    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; pcsource = 2'b00; bpc = '0; jpc = '0; da = '0;
        wpcir = 1'b1; imem_ready = 1'b1;
        tick; tick;
        chk("rst_pc", pc, 32'h0);
        chk("rst_dpc4", dpc4, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_redir", {31'd0, redir_pend}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        resetn = 1'b1;

        // Sequential fetch
        tick;
        chk("seq0_inst", inst, 32'hC0DE_0000);
        chk("seq0_dpc4", dpc4, 32'h4);
        chk("seq0_pc", pc, 32'h4);
        tick;
        chk("seq1_inst", inst, 32'hC0DE_0004);
        chk("seq1_dpc4", dpc4, 32'h8);
        chk("seq1_pc", pc, 32'h8);

        // Load-use stall at pc=8
        wpcir = 1'b0;
        tick;
        chk("stall_pc", pc, 32'h8);
        chk("stall_dpc4", dpc4, 32'h8);
        chk("stall_inst", inst, 32'hC0DE_0004);
        wpcir = 1'b1;
        tick;
        chk("post_stall_inst", inst, 32'hC0DE_0008);
        chk("post_stall_dpc4", dpc4, 32'hC);
        tick;
        tick;
        chk("pre_br_inst", inst, 32'hC0DE_0010);
        chk("pre_br_pc", pc, 32'h14);

        // Branch in ID, delay slot ready
        pcsource = 2'b01; bpc = 32'h40;
        tick;
        chk("br_ds_inst", inst, 32'hC0DE_0014);
        chk("br_ds_dpc4", dpc4, 32'h18);
        chk("br_pc", pc, 32'h40);
        chk("br_redir", {31'd0, redir_pend}, 32'd0);
        pcsource = 2'b00;
        tick;
        chk("br_tgt_inst", inst, 32'hC0DE_0040);
        chk("br_tgt_pc", pc, 32'h44);

        // Jump in ID, delay slot misses twice, plus a stall while pending
        pcsource = 2'b11; jpc = 32'h100; imem_ready = 1'b0;
        tick;
        chk("miss1_inst", inst, 32'h0);
        chk("miss1_dpc4", dpc4, 32'h48);
        chk("miss1_pc", pc, 32'h44);
        chk("miss1_redir", {31'd0, redir_pend}, 32'd1);
        pcsource = 2'b00;
        tick;
        chk("miss2_inst", inst, 32'h0);
        chk("miss2_pc", pc, 32'h44);
        chk("miss2_redir", {31'd0, redir_pend}, 32'd1);
        wpcir = 1'b0; imem_ready = 1'b1;
        tick;
        chk("redir_stall_pc", pc, 32'h44);
        chk("redir_stall_redir", {31'd0, redir_pend}, 32'd1);
        wpcir = 1'b1;
        tick;
        chk("miss_ds_inst", inst, 32'hC0DE_0044);
        chk("miss_ds_dpc4", dpc4, 32'h48);
        chk("miss_tgt_pc", pc, 32'h100);
        chk("miss_redir_clr", {31'd0, redir_pend}, 32'd0);

        // jr into REDIR, then async reset mid-REDIR
        pcsource = 2'b10; da = 32'h80; imem_ready = 1'b0;
        tick;
        chk("jr_redir", {31'd0, redir_pend}, 32'd1);
        chk("jr_pc", pc, 32'h100);
        pcsource = 2'b00;
        #3 resetn = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_dpc4", dpc4, 32'h0);
        chk("mid_rst_redir", {31'd0, redir_pend}, 32'd0);
        resetn = 1'b1; imem_ready = 1'b1;
        tick;
        chk("resume_inst", inst, 32'hC0DE_0000);
        chk("resume_pc", pc, 32'h4);

        // PC+4 wrap at top of address space
        pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
        tick;
        chk("wrap_jmp_pc", pc, 32'hFFFF_FFFC);
        pcsource = 2'b00;
        tick;
        chk("wrap_dpc4", dpc4, 32'h0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_inst", inst, 32'hC0DE_FFFC);

`ifdef IF_PERF_EN
        resetn = 1'b0;
        #1;
        chk("perf_rst_fetch", perf_fetch, 32'd0);
        chk("perf_rst_bubble", perf_bubble, 32'd0);
        resetn = 1'b1;
        imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        wpcir = 1'b0;
        for (int i = 0; i < 2; i++) tick;
        chk("perf_fetch", perf_fetch, 32'd5);
        chk("perf_bubble", perf_bubble, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_if_stage.md
# pipe_if_stage

Instruction-fetch stage plus IF/ID pipeline register of the five-stage pipelined computer. It holds the PC, selects the next PC from the ID stage's `pcsource`/`bpc`/`jpc`/`da` (ID-resolved branches and jumps, one architectural delay slot), and fetches from a wait-state instruction memory. It delivers `dpc4`/`inst` to the ID stage. On instruction-memory misses it inserts NOP bubbles, and it keeps a redirect pending so that no taken branch or jump is lost.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `NOP`, 32'h0000_0000, bubble instruction (sll r0,r0,0)

Ports:
- `clock`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `pcsource`  in  2  from ID: 00 pc+4, 01 `bpc`, 10 `da` (jr), 11 `jpc`
- `bpc`  in  32  branch target from ID
- `jpc`  in  32  jump target from ID
- `da`  in  32  forwarded rs value from ID (jr target)
- `wpcir`  in  1  1 = PC and IF/ID may update; 0 = load-use stall
- `imem_addr`  out  32  fetch address (= `pc`)
- `imem_rdata`  in  32  instruction word, valid when `imem_ready`=1
- `imem_ready`  in  1  1 = `imem_rdata` valid for `imem_addr` this cycle
- `pc`  out  32  current fetch PC
- `dpc4`  out  32  IF/ID: address of fetched instruction + 4
- `inst`  out  32  IF/ID: instruction to ID
- `redir_pend`  out  1  1 = FSM in REDIR
- `perf_fetch`, `perf_bubble`  out  32 each  present only with `IF_PERF_EN`

## Operation
- `pc4 = pc + 4`, modulo 2^32 (0xFFFF_FFFC + 4 = 0). `imem_addr = pc` combinationally.
- `target` = mux(`pcsource`): 00 `pc4`, 01 `bpc`, 10 `da`, 11 `jpc`.
- FSM states:
  - RUN: no redirect pending.
  - REDIR: a taken redirect is latched in `pend_pc`.
- Per rising edge, first matching rule applies:
  1. `wpcir`=0: hold `pc`, `dpc4`, `inst`, state and `pend_pc`. Fetch data is discarded and refetched later.
  2. `wpcir`=1, `imem_ready`=1: `dpc4<=pc4`, `inst<=imem_rdata`.
     - In REDIR: `pc<=pend_pc`, go to RUN.
     - In RUN: `pc<=target`.
  3. `wpcir`=1, `imem_ready`=0: `inst<=NOP`, `dpc4<=pc4`, `pc` held.
     - In RUN with `pcsource`≠00: `pend_pc<=target`, go to REDIR.
     - In REDIR: stay, `pend_pc` unchanged.
- Why REDIR exists: the branch in ID leaves ID on this edge and its `pcsource` will not be seen again. The delay slot at `pc` is still fetched and delivered before the redirect is taken.
- In REDIR, ID holds only bubbles, so `pcsource` is 00 and is ignored.
- Reset (async, any state, including mid-REDIR): `pc=RESET_PC`, `dpc4=0`, `inst=NOP`, `pend_pc=0`, state RUN, counters 0. The pending redirect is dropped.

## Timing
- Fetch-to-ID latency is one edge when `imem_ready`=1 at the cycle the address is presented.
- A taken branch in ID at cycle N with a ready delay-slot fetch puts the target on `imem_addr` at N+1.
- A delay-slot miss delays the redirect until the edge after the delay slot is captured. Each miss cycle costs one bubble.
- `wpcir` has priority over `imem_ready`. A stall during a miss inserts no bubble.
- All outputs are registered except `imem_addr`/`pc` (register output) and `redir_pend` (state decode).

## Configuration
- `IF_PERF_EN` defined:
  - `perf_fetch` increments on every rule-2 edge.
  - `perf_bubble` increments on every rule-3 edge.
  - Both are 32-bit, wrap at 2^32, and are cleared by reset.
- `IF_PERF_EN` undefined: both ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Sequential fetch: reset, `imem_ready`=1, `pcsource`=00, `wpcir`=1 → `inst` follows words at 0,4,8. `dpc4` = 4,8,12 on successive edges.
- Load-use stall: `wpcir`=0 for 1 cycle at pc=8 → `pc`, `dpc4`, `inst` unchanged for that edge. Next edge loads word@8.
- Branch, ready delay slot: branch at 0x10 in ID, `pcsource`=01, `bpc`=0x40, pc=0x14 → `inst`=word@0x14, then `pc`=0x40, `redir_pend`=0.
- Branch, delay-slot miss: as above with `imem_ready`=0 for 2 cycles → two NOP bubbles, `redir_pend`=1, `pc`=0x14 held. On the ready edge `inst`=word@0x14 and `pc`=0x40.
- jr plus reset mid-REDIR: `pcsource`=10, `da`=0x80, miss → REDIR. Assert `resetn`=0 → immediately `pc`=RESET_PC, `inst`=NOP, `redir_pend`=0. After release, fetch resumes at RESET_PC.
- With `IF_PERF_EN`: 5 ready edges, 3 miss edges, 2 stall edges → `perf_fetch`=5, `perf_bubble`=3.
